// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the CPU controller and the HI/LO multiply-divide unit.
// The controller drives clk_enable, start, op and operands; the unit returns status and HI/LO.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             clk_enable;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clk_enable, start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  clk_enable, start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO pair; also services MTHI/MTLO.
// Magnitudes are iterated unsigned (shift-add / restoring divide); signs are fixed in a final FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 zero_div_q, zero_div_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 signed_op_s;
    logic [WIDTH-1:0]     a_abs_s;
    logic [WIDTH-1:0]     b_abs_s;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] twos_neg_dbl(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = twos_neg(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Upper half accumulates the partial product, lower half shifts out the multiplier.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        if (acc[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0]     shifted;
        logic [WIDTH:0]     diff;
        logic [2*WIDTH-1:0] r;
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, dvsr};
        if (diff[WIDTH]) begin
            r = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            r = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        return r;
    endfunction

    assign signed_op_s = ~bus.op[0];
    assign a_abs_s     = signed_op_s ? abs_val(bus.a) : bus.a;
    assign b_abs_s     = signed_op_s ? abs_val(bus.b) : bus.b;

    // Next-state and datapath decision for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        zero_div_d = zero_div_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = bus.op[1];
                            neg_quo_d = signed_op_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d = signed_op_s & bus.a[WIDTH-1];
                            dbz_d     = 1'b0;
                            busy_d    = 1'b1;
                            cnt_d     = CNT_W'(WIDTH);
                            if (bus.op[1] && (bus.b == {WIDTH{1'b0}})) begin
                                // Divide by zero skips iteration; FIX reports raw dividend in HI.
                                zero_div_d = 1'b1;
                                state_d    = ST_FIX;
                                acc_d      = {{WIDTH{1'b0}}, bus.a};
                                opnd_d     = {WIDTH{1'b0}};
                            end else begin
                                zero_div_d = 1'b0;
                                state_d    = ST_RUN;
                                if (bus.op[1]) begin
                                    acc_d  = {{WIDTH{1'b0}}, a_abs_s};
                                    opnd_d = b_abs_s;
                                end else begin
                                    acc_d  = {{WIDTH{1'b0}}, b_abs_s};
                                    opnd_d = a_abs_s;
                                end
                            end
                        end
                        OP_MTHI: begin
                            hi_d  = bus.a;
                            dbz_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d  = bus.a;
                            dbz_d = 1'b0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (is_div_q) begin
                    acc_d = div_step(acc_q, opnd_q);
                end else begin
                    acc_d = mul_step(acc_q, opnd_q);
                end
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zero_div_q) begin
                    hi_d  = acc_q[WIDTH-1:0];
                    lo_d  = {WIDTH{1'b1}};
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_quo_q ? twos_neg(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? twos_neg(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_quo_q ? twos_neg_dbl(acc_q) : acc_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; clk_enable low freezes everything including done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            zero_div_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else if (bus.clk_enable) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            zero_div_q <= zero_div_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32 and WIDTH=8 using hand-computed vectors.
module tb_mul_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
        int          blen;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb32[$];
    exp_t sb8[$];

    int   bc32 = 0;
    int   bc8  = 0;
    logic pd32 = 1'b0;
    logic pd8  = 1'b0;
    logic pe32 = 1'b1;
    logic pe8  = 1'b1;

    mul_div_unit_if #(.WIDTH(32)) if32 ();
    mul_div_unit_if #(.WIDTH(8))  if8 ();

    mul_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(rst_n), .bus(if32.slave));
    mul_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst_n), .bus(if8.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e, input logic [31:0] hi,
                               input logic [31:0] lo, input logic dbz, input logic busy,
                               input int bcnt);
        chk({tag, " hi"},       hi, e.hi);
        chk({tag, " lo"},       lo, e.lo);
        chk({tag, " dbz"},      {31'd0, dbz}, {31'd0, e.dbz});
        chk({tag, " busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, " done_cyc"}, cyc, e.due);
        chk({tag, " busy_len"}, bcnt, e.blen);
    endtask

    // Monitor for the 32-bit unit: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            bc32 = 0;
            pd32 = 1'b0;
        end else begin
            if (pd32) begin
                chk("w32 done_width", {31'd0, if32.done & pe32}, 32'd0);
            end
            if (if32.busy) bc32++;
            if (if32.done && !pd32) begin
                if (sb32.size() == 0) begin
                    chk("w32 spurious_done", 32'd1, 32'd0);
                end else begin
                    check_entry("w32", sb32.pop_front(), if32.hi, if32.lo,
                                if32.div_by_zero, if32.busy, bc32);
                end
                bc32 = 0;
            end
            pd32 = if32.done;
            pe32 = if32.clk_enable;
        end
    end

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        if (!rst_n) begin
            bc8 = 0;
            pd8 = 1'b0;
        end else begin
            if (pd8) begin
                chk("w8 done_width", {31'd0, if8.done & pe8}, 32'd0);
            end
            if (if8.busy) bc8++;
            if (if8.done && !pd8) begin
                if (sb8.size() == 0) begin
                    chk("w8 spurious_done", 32'd1, 32'd0);
                end else begin
                    check_entry("w8", sb8.pop_front(), {24'd0, if8.hi}, {24'd0, if8.lo},
                                if8.div_by_zero, if8.busy, bc8);
                end
                bc8 = 0;
            end
            pd8 = if8.done;
            pe8 = if8.clk_enable;
        end
    end

    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
        end else begin
            if8.start = 1'b1; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
        end
        @(negedge clk);
        if (sel == 0) if32.start = 1'b0;
        else          if8.start  = 1'b0;
        e.hi   = ehi;
        e.lo   = elo;
        e.dbz  = edbz;
        e.due  = cyc + lat;
        e.blen = lat;
        if (push) begin
            if (sel == 0) sb32.push_back(e);
            else          sb8.push_back(e);
        end
    endtask

    task automatic wait_idle(input int sel);
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if ((sel == 0 && sb32.size() == 0) || (sel != 0 && sb8.size() == 0)) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!drained) begin
            chk("done_timeout", 32'd1, 32'd0);
            if (sel == 0) sb32.delete();
            else          sb8.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if32.clk_enable = 1'b1; if32.start = 1'b0; if32.op = 3'b000; if32.a = 32'd0; if32.b = 32'd0;
        if8.clk_enable  = 1'b1; if8.start  = 1'b0; if8.op  = 3'b000; if8.a  = 8'd0;  if8.b  = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst hi32",   if32.hi, 32'd0);
        chk("rst lo32",   if32.lo, 32'd0);
        chk("rst busy32", {31'd0, if32.busy}, 32'd0);
        chk("rst done32", {31'd0, if32.done}, 32'd0);
        chk("rst dbz32",  {31'd0, if32.div_by_zero}, 32'd0);
        chk("rst busy8",  {31'd0, if8.busy}, 32'd0);
        chk("rst lo8",    {24'd0, if8.lo}, 32'd0);
        rst_n = 1'b1;

        issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1);
        wait_idle(0);
        issue(0, OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1);
        wait_idle(0);
        issue(0, OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b1);
        wait_idle(0);
        issue(0, OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0, 33, 1'b1);
        wait_idle(0);
        issue(0, OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b1);
        wait_idle(0);
        issue(0, OP_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1, 1'b1);
        wait_idle(0);
        repeat (2) @(negedge clk);
        chk("dbz sticky32", {31'd0, if32.div_by_zero}, 32'd1);
        issue(0, OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
        chk("dbz cleared32", {31'd0, if32.div_by_zero}, 32'd0);
        wait_idle(0);
        issue(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b1);
        wait_idle(0);

        // MULTU 6*7 with an ignored start and a 5-cycle stall mid-run.
        issue(0, OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 38, 1'b1);
        repeat (3) @(negedge clk);
        if32.start = 1'b1; if32.op = OP_MULT; if32.a = 32'd1; if32.b = 32'd1;
        @(negedge clk);
        if32.start = 1'b0;
        chk("busy mid_run32", {31'd0, if32.busy}, 32'd1);
        repeat (4) @(negedge clk);
        if32.clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        if32.clk_enable = 1'b1;
        wait_idle(0);

        @(negedge clk);
        if32.start = 1'b1; if32.op = OP_MTHI; if32.a = 32'h00001234;
        @(posedge clk); #1;
        chk("mthi hi32",   if32.hi, 32'h00001234);
        chk("mthi busy32", {31'd0, if32.busy}, 32'd0);
        chk("mthi done32", {31'd0, if32.done}, 32'd0);
        @(negedge clk);
        if32.op = OP_MTLO; if32.a = 32'h00005678;
        @(posedge clk); #1;
        chk("mtlo lo32",   if32.lo, 32'h00005678);
        chk("mtlo hi32",   if32.hi, 32'h00001234);
        chk("mtlo done32", {31'd0, if32.done}, 32'd0);
        @(negedge clk);
        if32.start = 1'b0;

        // Asynchronous reset abandons a DIVU in its tenth cycle.
        issue(0, OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 33, 1'b0);
        repeat (9) @(negedge clk);
        chk("busy pre_rst32", {31'd0, if32.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst busy32", {31'd0, if32.busy}, 32'd0);
        chk("async_rst done32", {31'd0, if32.done}, 32'd0);
        chk("async_rst hi32",   if32.hi, 32'd0);
        chk("async_rst lo32",   if32.lo, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(0, OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 1'b1);
        wait_idle(0);

        issue(1, OP_MULT,  32'h000000F9, 32'h00000003, 32'h000000FF, 32'h000000EB, 1'b0, 9, 1'b1);
        wait_idle(1);
        issue(1, OP_DIV,   32'h000000F9, 32'h00000002, 32'h000000FF, 32'h000000FD, 1'b0, 9, 1'b1);
        wait_idle(1);
        issue(1, OP_MULTU, 32'h000000FF, 32'h000000FF, 32'h000000FE, 32'h00000001, 1'b0, 9, 1'b1);
        wait_idle(1);
        issue(1, OP_DIVU,  32'd100, 32'd0, 32'd100, 32'h000000FF, 1'b1, 1, 1'b1);
        wait_idle(1);
        issue(1, OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 9, 1'b1);
        wait_idle(1);
        issue(1, OP_DIV,   32'h00000080, 32'h000000FF, 32'h00000000, 32'h00000080, 1'b0, 9, 1'b1);
        wait_idle(1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO register pair for the MIPS CPU.
- Sits beside the ALU in the datapath. Started by the controller with operands from the register file; the controller stalls the PC while busy is high.
- Parametrised in operand width. Gives the datapath multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO support, which the single-cycle ALU path lacks.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits. Legal values are even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clk_enable  input  1  when low, all state holds (matches CPU stall)
- start  input  1  request operation op; sampled only when busy=0 and clk_enable=1
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  high while an iterative op is in progress
- done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- div_by_zero  output  1  sticky flag, set by DIV/DIVU with b=0, cleared at next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and internal accumulators cleared. Applies mid-operation; the operation is abandoned.
- clk_enable=0: no register changes. done holds its value.
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - MULT/MULTU/DIV/DIVU: latch the operands and enter RUN. busy=1 from the next cycle; counter=WIDTH.
  - Signed ops latch |a| and |b| (WIDTH-bit unsigned) and record sign_q=a[W-1]^b[W-1] and sign_r=a[W-1].
  - Unsigned ops use the operands as-is with signs 0.
  - MTHI/MTLO: write hi/lo at that same edge and stay IDLE. busy and done stay 0.
  - Undefined op: no effect.
- RUN: one iteration per enabled edge, counter decrements.
  - Multiply is shift-add over a 2*WIDTH accumulator.
  - Divide is restoring: shift the remainder left, subtract the divisor, keep the result if non-negative, set the quotient bit.
  - When counter reaches 0, go to FIX.
- FIX (one edge): apply the sign fix-up and write hi/lo, then go to IDLE. busy=0 and done=1 for exactly the following cycle.
  - Multiply: {hi,lo} = sign_q ? -(prod) : prod, in 2*WIDTH two's complement.
  - Divide: lo = quotient (negated if sign_q), hi = remainder (negated if sign_r).
- Latency: start edge E0. hi/lo update at edge E(WIDTH+1). busy is high from E0 to E(WIDTH+1). done is high from E(WIDTH+1) to E(WIDTH+2).
- start while busy=1 is ignored. It is not queued, and operands are taken only at acceptance.
- Back-to-back: start may be accepted in the cycle done=1, since busy=0 there.
- hi/lo are stable during RUN and hold their previous values until FIX.
- Division by zero, DIV or DIVU with b=0:
  - No iteration; FIX is reached at the next edge. Latency is 2 edges and done pulses normally.
  - hi=a (raw), lo=all ones, div_by_zero=1.
- Overflow, DIV of most-negative by -1: lo=most-negative (e.g. 0x80000000), hi=0. No flag.
- All arithmetic is modulo 2^WIDTH per register; no saturation.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles after acceptance; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100 b=0 -> done after 2 edges; hi=100, lo=0xFFFFFFFF, div_by_zero=1. Next accepted DIVU 100/7 -> flag clears; lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. Separately MTHI 0x1234 and MTLO 0x5678 -> hi/lo update at the start edge; busy and done stay 0.
- Start MULTU 6*7, pulse start with MULT 1*1 mid-RUN, and drop clk_enable for 5 cycles mid-RUN -> second start ignored; done delayed by exactly 5 cycles; lo=42.
- Assert reset at cycle 10 of a DIVU -> busy, done, hi and lo are 0 immediately, with no waiting for a clock edge. A new MULTU 3*5 after release gives lo=15.
- Repeat the 2nd and 3rd scenarios at WIDTH=8 -> latency is 9 edges and the results match the 8-bit equivalents.
